sram_page_writer: RTL
=====================

# sram_page_writer

Write-side page builder sitting directly upstream of the SRAM state/ECC bookkeeping block. It accepts a word stream per packet, claims a free page (`null_ptr`) and signals `wr_op`/`wr_port` to the bookkeeping block, and writes the words into the data SRAM. At page close it writes one 8-bit ECC/fill code per page into ECC storage. Packets longer than one page are split across consecutive allocations.

## Interface
- `DATA_WIDTH`, 16, data word width; ECC code is defined for 16.
- `PAGE_WORDS`, 8, words per page; power of two.
- `PAGE_ADDR_WIDTH`, 11, page index width (2048 pages).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  word accepted when `in_valid && in_ready`.
- `in_data`  in  16  word.
- `in_last`  in  1  last word of packet.
- `in_port`  in  4  destination port; sampled on first word of packet only.
- `free_space`  in  11  free page count from bookkeeping.
- `null_ptr`  in  11  head of null-page FIFO.
- `wr_op`  out  1  one-cycle pulse; pops `null_ptr`.
- `wr_port`  out  4  port for `wr_op`.
- `sram_wr_en`  out  1  data SRAM write strobe.
- `sram_wr_addr`  out  14  `{page, word_idx[2:0]}`.
- `sram_din`  out  16  word written.
- `ecc_wr_en`, `ecc_wr_addr[10:0]`, `ecc_din[7:0]`  out  ECC storage write.
- `page_done`  out  1  pulse with `ecc_wr_en`.
- `stall`  out  1  high while waiting for `free_space != 0`.

## Operation
- FSM states: IDLE, ALLOC, FILL, CLOSE.
- IDLE: `in_ready=0`. If `in_valid`: latch `in_port` into packet port, go ALLOC.
- ALLOC: if `free_space==0`: `stall=1`, remain. Else pulse `wr_op`, `wr_port`=packet port, latch `page<=null_ptr`, clear `word_idx` and ECC accumulator, go FILL.
- FILL: `in_ready=1`. Each accepted word is registered: next cycle `sram_wr_en=1`, `sram_wr_addr={page,word_idx}`, `sram_din=in_data`. `word_idx` increments. The ECC accumulator is XORed with the word's Hamming check bits. Page closes on acceptance of a word with `in_last`, or of the word with `word_idx==PAGE_WORDS-1`. On close go CLOSE and record whether `in_last` was seen. `in_port` is ignored after the first word.
- CLOSE: `in_ready=0`. `ecc_wr_en=1`, `page_done=1`, `ecc_wr_addr=page`, `ecc_din={fill_count-1[2:0], acc[4:0]}`, where `fill_count` is 1..8. Next state is IDLE if last was seen, else ALLOC with the same port.
- Hamming check bits: data bit d0..d15 map to codeword positions 3,5,6,7,9..15,17..21. `p_k` is the XOR of the data bits whose position has bit k set. `acc[0]=p1`, `[1]=p2`, `[2]=p4`, `[3]=p8`, `[4]=p16`.
- Exactly one `wr_op` per page. Never more than one `wr_op` per 3 cycles, so `free_space` is always current when sampled.
- Reset mid-operation: return to IDLE and zero all outputs. A partially filled page gets no ECC write, and the popped page is not returned.

## Timing
- Reset values: `in_ready`, `wr_op`, `wr_port`, `sram_wr_en`, `sram_wr_addr`, `sram_din`, `ecc_wr_en`, `ecc_wr_addr`, `ecc_din`, `page_done`, `stall` are all 0. State is IDLE.
- `in_valid` seen in IDLE at cycle T: ALLOC at T+1 (`wr_op` at T+1 if space), FILL at T+2.
- SRAM write lags word acceptance by 1 cycle.
- ECC write occurs the cycle after the closing word is accepted, concurrent with that word's SRAM write.
- A full 8-word page takes 11 cycles from `in_valid` (IDLE, ALLOC, 8 FILL, CLOSE). Each continuation page takes 10 cycles (ALLOC, 8 FILL, CLOSE).
- `in_valid` low during FILL: hold, no timeout.

## Test plan
- 1-word packet 0x0001, port 3, `null_ptr=5`, `free_space=2047`:
  - `wr_op=1` with `wr_port=3`.
  - SRAM write addr 40, data 0x0001.
  - ECC write addr 5, `ecc_din=0x03`.
  - `page_done` 1 cycle.
- 8-word packet of 0x0001, `null_ptr=9`:
  - SRAM addrs 72..79.
  - `ecc_din=0xE0`.
  - Exactly one `wr_op`.
- 9-word packet, `null_ptr` 9 then 4:
  - Two `wr_op` pulses on the same port.
  - Second page gets SRAM addr 32 and `ecc_din={3'd0, acc}` for word 9.
  - Returns to IDLE.
- `free_space=0` at ALLOC:
  - `stall=1`, no `wr_op`, `in_ready=0`.
  - Raising `free_space` to 1 → `wr_op` next cycle, FILL follows.
- Assert `rst` mid-FILL after 3 words:
  - All outputs 0 next cycle; no `ecc_wr_en`.
  - A new packet then proceeds normally.
- `in_port` changed to 7 on word 2 of a port-2 packet spanning 2 pages: both `wr_op` pulses carry `wr_port=2`.

Source files
------------

// File: rtl/sram_page_writer_if.sv
// Bundles the packet word stream, page-allocation handshake and the SRAM/ECC write ports.
// Latency: none, wiring only.
// Backpressure: in_ready comes from the writer; free_space from bookkeeping gates allocation.
interface sram_page_writer_if #(
   parameter int DATA_WIDTH      = 16,
   parameter int PAGE_WORDS      = 8,
   parameter int PAGE_ADDR_WIDTH = 11
);
   localparam int IDX_W = $clog2(PAGE_WORDS);

   // packet word stream
   logic                             in_valid;
   logic                             in_ready;
   logic [DATA_WIDTH-1:0]            in_data;
   logic                             in_last;
   logic [3:0]                       in_port;

   // page allocation handshake with bookkeeping
   logic [PAGE_ADDR_WIDTH-1:0]       free_space;
   logic [PAGE_ADDR_WIDTH-1:0]       null_ptr;
   logic                             wr_op;
   logic [3:0]                       wr_port;

   // data SRAM write port
   logic                             sram_wr_en;
   logic [PAGE_ADDR_WIDTH+IDX_W-1:0] sram_wr_addr;
   logic [DATA_WIDTH-1:0]            sram_din;

   // ECC storage write port
   logic                             ecc_wr_en;
   logic [PAGE_ADDR_WIDTH-1:0]       ecc_wr_addr;
   logic [IDX_W+4:0]                 ecc_din;
   logic                             page_done;
   logic                             stall;

   modport slave (
      input  in_valid, in_data, in_last, in_port, free_space, null_ptr,
      output in_ready, wr_op, wr_port, sram_wr_en, sram_wr_addr, sram_din,
      output ecc_wr_en, ecc_wr_addr, ecc_din, page_done, stall
   );

   modport master (
      output in_valid, in_data, in_last, in_port, free_space, null_ptr,
      input  in_ready, wr_op, wr_port, sram_wr_en, sram_wr_addr, sram_din,
      input  ecc_wr_en, ecc_wr_addr, ecc_din, page_done, stall
   );
endinterface

// File: rtl/sram_page_writer.sv
// Packs a packet word stream into SRAM pages, claiming one free page per page and writing a per-page ECC/fill code.
// Latency: SRAM write 1 cycle after word acceptance; ECC write in the cycle after the closing word.
// Backpressure: in_ready only in FILL; allocation stalls (stall=1) while free_space is zero.
module sram_page_writer #(
   parameter int DATA_WIDTH      = 16,
   parameter int PAGE_WORDS      = 8,
   parameter int PAGE_ADDR_WIDTH = 11
) (
   input logic               clk,
   input logic               rst,
   sram_page_writer_if.slave bus
);
   localparam int               IDX_W    = $clog2(PAGE_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALLOC = 2'd1,
      S_FILL  = 2'd2,
      S_CLOSE = 2'd3
   } state_t;

   state_t                           state_q, state_d;
   logic [3:0]                       port_q, port_d;      // packet port, held across continuation pages
   logic [PAGE_ADDR_WIDTH-1:0]       page_q, page_d;      // page claimed at the last allocation
   logic [IDX_W-1:0]                 idx_q, idx_d;        // next word slot in the page
   logic [IDX_W-1:0]                 fill_q, fill_d;      // slot of the closing word (fill count - 1)
   logic [4:0]                       acc_q, acc_d;        // running XOR of per-word Hamming check bits
   logic                             last_q, last_d;      // closing word carried in_last
   logic                             sram_en_q, sram_en_d;
   logic [PAGE_ADDR_WIDTH+IDX_W-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_WIDTH-1:0]            sram_din_q, sram_din_d;

   // Codeword position of each data bit; powers of two are reserved for parity bits.
   function automatic logic [4:0] code_pos(input int i);
      logic [4:0] p;
      case (i)
         0:       p = 5'd3;
         1:       p = 5'd5;
         2:       p = 5'd6;
         3:       p = 5'd7;
         4:       p = 5'd9;
         5:       p = 5'd10;
         6:       p = 5'd11;
         7:       p = 5'd12;
         8:       p = 5'd13;
         9:       p = 5'd14;
         10:      p = 5'd15;
         11:      p = 5'd17;
         12:      p = 5'd18;
         13:      p = 5'd19;
         14:      p = 5'd20;
         15:      p = 5'd21;
         default: p = 5'd0;
      endcase
      return p;
   endfunction

   // Bit k of the XOR of positions of set data bits equals parity p_(2^k).
   function automatic logic [4:0] hamming_chk(input logic [15:0] d);
      logic [4:0] chk;
      chk = '0;
      for (int i = 0; i < 16; i++) begin
         if (d[i]) begin
            chk = chk ^ code_pos(i);
         end
      end
      return chk;
   endfunction

   // Next-state and handshake/ECC outputs; everything defaults to idle values first.
   always_comb begin
      state_d       = state_q;
      port_d        = port_q;
      page_d        = page_q;
      idx_d         = idx_q;
      fill_d        = fill_q;
      acc_d         = acc_q;
      last_d        = last_q;
      sram_en_d     = 1'b0;
      sram_addr_d   = '0;
      sram_din_d    = '0;
      bus.in_ready    = 1'b0;
      bus.wr_op       = 1'b0;
      bus.wr_port     = '0;
      bus.stall       = 1'b0;
      bus.ecc_wr_en   = 1'b0;
      bus.ecc_wr_addr = '0;
      bus.ecc_din     = '0;
      bus.page_done   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // The first word is presented with its port; take the port now, the word in FILL.
            if (bus.in_valid) begin
               port_d  = bus.in_port;
               state_d = S_ALLOC;
            end
         end

         S_ALLOC: begin
            if (bus.free_space == '0) begin
               bus.stall = 1'b1;
            end else begin
               bus.wr_op   = 1'b1;
               bus.wr_port = port_q;
               page_d      = bus.null_ptr;
               idx_d       = '0;
               acc_d       = '0;
               last_d      = 1'b0;
               state_d     = S_FILL;
            end
         end

         S_FILL: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               sram_en_d   = 1'b1;
               sram_addr_d = {page_q, idx_q};
               sram_din_d  = bus.in_data;
               idx_d       = idx_q + 1'b1;
               acc_d       = acc_q ^ hamming_chk(bus.in_data);
               if (bus.in_last || (idx_q == LAST_IDX)) begin
                  last_d  = bus.in_last;
                  fill_d  = idx_q;
                  state_d = S_CLOSE;
               end
            end
         end

         S_CLOSE: begin
            // Closing word's SRAM write goes out this same cycle from the pipeline register.
            bus.ecc_wr_en   = 1'b1;
            bus.page_done   = 1'b1;
            bus.ecc_wr_addr = page_q;
            bus.ecc_din     = {fill_q, acc_q};
            state_d         = last_q ? S_IDLE : S_ALLOC;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; synchronous reset drops any partial page.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         port_q      <= '0;
         page_q      <= '0;
         idx_q       <= '0;
         fill_q      <= '0;
         acc_q       <= '0;
         last_q      <= 1'b0;
         sram_en_q   <= 1'b0;
         sram_addr_q <= '0;
         sram_din_q  <= '0;
      end else begin
         state_q     <= state_d;
         port_q      <= port_d;
         page_q      <= page_d;
         idx_q       <= idx_d;
         fill_q      <= fill_d;
         acc_q       <= acc_d;
         last_q      <= last_d;
         sram_en_q   <= sram_en_d;
         sram_addr_q <= sram_addr_d;
         sram_din_q  <= sram_din_d;
      end
   end

   assign bus.sram_wr_en   = sram_en_q;
   assign bus.sram_wr_addr = sram_addr_q;
   assign bus.sram_din     = sram_din_q;

endmodule
